regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-read-port register file with an integrated pending-write scoreboard and a post-reset clearing sequencer. It replaces the fixed 32 x 32, two-read-port register file in the CPU datapath. Decode uses the per-port `ready` outputs for hazard stalls. Writeback commits results and retires scoreboard entries.

## Interface
Parameters:
- `WIDTH`, 32, data width in bits.
- `DEPTH`, 32, number of entries; power of two, at least 4.
- `NREAD`, 2, number of read ports, 1..4.
- Derived: `AW = $clog2(DEPTH)`.

Ports:
- `clk` in 1: clock, single clock domain, posedge.
- `rst` in 1: reset, asynchronous, active-high.
- `we` in 1: write enable.
- `writeaddr` in AW: write address.
- `writedata` in WIDTH: write data.
- `readaddr` in NREAD*AW: packed read addresses; port i is at `[i*AW +: AW]`.
- `readdata` out NREAD*WIDTH: packed read data, same packing as `readaddr`.
- `ready` out NREAD: port i holds no outstanding pending write.
- `mark` in 1: issue strobe; sets the pending bit of `markaddr`.
- `markaddr` in AW: destination register of the issuing instruction.
- `init_busy` out 1: clearing sequence in progress.

## Operation
- Entry 0 is hardwired:
  - reads of entry 0 return 0;
  - writes to entry 0 are dropped;
  - `mark` to entry 0 is ignored;
  - `ready` for entry 0 is always 1.
- Clearing FSM states: CLEAR and RUN.
  - `rst` asserted: state=CLEAR, counter=0, all pending bits=0, `init_busy`=1.
  - In CLEAR: each cycle writes 0 to `mem[counter]` and increments the counter. After `counter == DEPTH-1` is written, the FSM moves to RUN.
  - In RUN: `init_busy`=0. The FSM leaves RUN only on `rst`.
- Behaviour during CLEAR:
  - `we` and `mark` are ignored;
  - `readdata` = 0 on all ports;
  - `ready` = 0 on all ports.
- Writes in RUN: `we` with `writeaddr != 0` stores `writedata` at the next posedge and clears `pending[writeaddr]`.
- Scoreboard in RUN: `mark` sets `pending[markaddr]` at the posedge.
- `mark` and `we` to the same address in the same cycle: the data is written and the pending bit ends at 1 (the new producer wins).
- `ready[i]` = `!pending[readaddr_i]`, modified by bypass (see Configuration).
- All read ports are independent. Any number of ports may read the same address.
- Address arithmetic: the clear counter is AW+1 bits so the terminal count does not wrap.

## Timing
- Read latency: 0. `readdata` and `ready` are combinational from `readaddr` and state.
- Write latency: 1 clock. Scoreboard update latency: 1 clock.
- Clear duration: exactly DEPTH cycles after `rst` deasserts. `init_busy` falls on the edge that completes entry DEPTH-1.
- Reset values:
  - `init_busy`=1;
  - `readdata`=0;
  - `ready`=0;
  - pending=all 0;
  - FSM=CLEAR.
- `rst` asserted mid-CLEAR or mid-RUN restarts the clear from entry 0 immediately (asynchronous).
- Memory contents are not reset directly; only the sequencer zeroes them.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - A read whose address equals `writeaddr` while `we`=1 (RUN state, address != 0) returns `writedata` in the same cycle.
  - `ready` for that port is 1 in that cycle, even if the pending bit is set.
- `REGFILE_BYPASS_EN` undefined:
  - The read returns the stored (old) value during the write cycle.
  - `ready` rises one cycle after the write commits.

## Structure
- Package `regfile_pkg` holds:
  - the FSM state enum `rf_state_t` {CLEAR, RUN};
  - a `rf_unpack_addr` helper function.
- Sub-module `regfile_scoreboard` holds:
  - the DEPTH-bit pending vector;
  - its set/clear/priority logic;
  - the per-port `ready` generation, including the bypass term under the macro.
- The top level holds the storage array, the clear FSM, and the read muxes.

## Test plan
- Release `rst`, DEPTH=32 → `init_busy`=1 for exactly 32 cycles; afterwards every address reads 0 and every `ready`=1.
- Write 0xDEADBEEF to entry 5, then read entry 5 on ports 0 and 1 → both return 0xDEADBEEF. Write 0x1234 to entry 0 → entry 0 still reads 0.
- `mark` entry 7 → `ready`=0 on a port reading 7. Write entry 7 with 0xA5 → `ready`=1 in the write cycle with bypass, the next cycle without; data is 0xA5.
- `mark` and `we` to entry 9 in the same cycle → entry 9 holds the new data and its pending bit stays set (`ready`=0).
- Assert `rst` for 1 cycle mid-clear at counter=10 → clear restarts and `init_busy` stays high 32 more cycles.
- NREAD=4, all ports reading distinct entries 1–4 preloaded with 0x11..0x44 → each port returns its own value in the same cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and helpers for the regfile_mp register file.
//   rf_state_t     : clearing-sequencer states (CLEAR, RUN)
//   rf_unpack_addr : extracts read port idx's address from a packed address bus
`timescale 1ns/1ps
package regfile_pkg;

    typedef enum logic {
        CLEAR,
        RUN
    } rf_state_t;

    // Upper bounds for the packed read-address bus handled by rf_unpack_addr.
    localparam int unsigned RF_MAX_AW     = 16;
    localparam int unsigned RF_MAX_NREAD  = 4;
    localparam int unsigned RF_ADDR_BUS_W = RF_MAX_AW * RF_MAX_NREAD;

    // Returns bits [idx*aw +: aw] of bus, zero-extended to RF_MAX_AW bits.
    function automatic logic [RF_MAX_AW-1:0] rf_unpack_addr(
        input logic [RF_ADDR_BUS_W-1:0] bus,
        input int unsigned              idx,
        input int unsigned              aw
    );
        logic [RF_MAX_AW-1:0] res;
        res = '0;
        for (int unsigned b = 0; b < RF_MAX_AW; b++) begin
            if (b < aw) begin
                res[b] = bus[idx*aw + b];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-write scoreboard for regfile_mp.
//   clk, rst      : clock, asynchronous active-high reset (clears all pending bits)
//   set_en/addr   : issue strobe, sets pending[set_addr] (caller gates with RUN/addr!=0)
//   clr_en/addr   : write commit, clears pending[clr_addr] (caller gates likewise)
//   run           : sequencer is in RUN; ready is forced low otherwise
//   rd_addr       : packed read addresses, port i at [i*AW +: AW]
//   ready         : per port, the addressed register has no outstanding producer
// Optional feature macro: REGFILE_BYPASS_EN (a committing write makes ready
// high in the same cycle for ports reading the written address).
`timescale 1ns/1ps
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned NREAD = 2,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                set_en,
    input  logic [AW-1:0]       set_addr,
    input  logic                clr_en,
    input  logic [AW-1:0]       clr_addr,
    input  logic [NREAD*AW-1:0] rd_addr,
    output logic [NREAD-1:0]    ready
);

    logic [DEPTH-1:0]         pending_q;
    logic [DEPTH-1:0]         pending_d;
    logic [RF_ADDR_BUS_W-1:0] ra_bus;
    logic [AW-1:0]            ra [NREAD];

    // Clear first, then set: an issue in the same cycle as a commit to the
    // same register leaves the newer producer outstanding.
    always_comb begin
        pending_d = pending_q;
        if (clr_en) begin
            pending_d[clr_addr] = 1'b0;
        end
        if (set_en) begin
            pending_d[set_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_comb begin
        ra_bus = RF_ADDR_BUS_W'(rd_addr);
        ready  = '0;
        for (int unsigned i = 0; i < NREAD; i++) begin
            ra[i] = AW'(rf_unpack_addr(ra_bus, i, AW));
            if (!run) begin
                ready[i] = 1'b0;
            end else if (ra[i] == '0) begin
                ready[i] = 1'b1;
            end else begin
`ifdef REGFILE_BYPASS_EN
                ready[i] = !pending_q[ra[i]] || (clr_en && (clr_addr == ra[i]));
`else
                ready[i] = !pending_q[ra[i]];
`endif
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file with a pending-write
// scoreboard and a post-reset clearing sequencer.
//   clk, rst    : clock, asynchronous active-high reset (restarts the clear)
//   we          : write enable, writeaddr/writedata: write port (entry 0 dropped)
//   readaddr    : packed read addresses, port i at [i*AW +: AW]
//   readdata    : packed read data, same packing (combinational)
//   ready       : per port, no outstanding pending write on the read address
//   mark        : issue strobe, sets pending[markaddr]
//   init_busy   : clearing sequence in progress
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding of data
// and ready in the write cycle).
`timescale 1ns/1ps
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned NREAD = 2,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [AW-1:0]          writeaddr,
    input  logic [WIDTH-1:0]       writedata,
    input  logic [NREAD*AW-1:0]    readaddr,
    output logic [NREAD*WIDTH-1:0] readdata,
    output logic [NREAD-1:0]       ready,
    input  logic                   mark,
    input  logic [AW-1:0]          markaddr,
    output logic                   init_busy
);

    localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);

    logic [WIDTH-1:0]         mem [DEPTH];
    rf_state_t                state_q;
    rf_state_t                state_d;
    logic [AW:0]              cnt_q;
    logic [AW:0]              cnt_d;
    logic                     run;
    logic                     wr_en;
    logic                     mk_en;
    logic [RF_ADDR_BUS_W-1:0] ra_bus;
    logic [AW-1:0]            ra [NREAD];

    // Clearing sequencer: one entry per cycle from 0 to DEPTH-1, then RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = CLEAR;
        endcase
    end

    assign run       = (state_q == RUN);
    assign init_busy = !run;
    assign wr_en     = run && we   && (writeaddr != '0);
    assign mk_en     = run && mark && (markaddr  != '0);

    // Storage has no reset; the sequencer is the only thing that zeroes it.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[cnt_q[AW-1:0]] <= '0;
        end else if (wr_en) begin
            mem[writeaddr] <= writedata;
        end
    end

    always_comb begin
        ra_bus   = RF_ADDR_BUS_W'(readaddr);
        readdata = '0;
        for (int unsigned i = 0; i < NREAD; i++) begin
            ra[i] = AW'(rf_unpack_addr(ra_bus, i, AW));
            if (!run || (ra[i] == '0)) begin
                readdata[i*WIDTH +: WIDTH] = '0;
            end else begin
`ifdef REGFILE_BYPASS_EN
                if (wr_en && (writeaddr == ra[i])) begin
                    readdata[i*WIDTH +: WIDTH] = writedata;
                end else begin
                    readdata[i*WIDTH +: WIDTH] = mem[ra[i]];
                end
`else
                readdata[i*WIDTH +: WIDTH] = mem[ra[i]];
`endif
            end
        end
    end

    regfile_scoreboard #(
        .DEPTH (DEPTH),
        .NREAD (NREAD),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .set_en   (mk_en),
        .set_addr (markaddr),
        .clr_en   (wr_en),
        .clr_addr (writeaddr),
        .rd_addr  (readaddr),
        .ready    (ready)
    );

endmodule
